// File: rtl/led_blink_array_if.sv
// led_blink_array_if: per-channel configuration write bus for the LED pattern generator.
interface led_blink_array_if #(
  parameter int CHANNELS = 4,
  parameter int HALF_W   = 16
);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [HALF_W-1:0] cfg_half;
  logic [3:0]        cfg_burst;
  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst);
endinterface

// File: rtl/led_blink_array.sv
// led_blink_array: multi-channel OFF/ON/BLINK/BURST LED pattern generator on a shared prescaled tick.
module led_blink_array #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 50000,
  parameter int HALF_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  led_blink_array_if.slave    cfg,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int PW   = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt;
  logic          tick_c;
  assign tick_c = cnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= tick_c ? '0 : cnt + 1'b1;
      tick <= tick_c;
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    typedef enum logic [2:0] {IDLE, B_HI, B_LO, U_HI, U_LO, GAP} st_t;
    st_t               st;
    logic [HALF_W-1:0] half, timer;
    logic [3:0]        burst, pc;
    logic              gp, led_r, wr;
    assign wr     = cfg.cfg_we && cfg.cfg_ch == CH_W'(c);
    assign led[c] = led_r;
    // GAP spans two half-length passes (gp marks the second) so 2*half never overflows
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st    <= IDLE;
        half  <= HALF_W'(1);
        burst <= 4'd1;
        timer <= '0;
        pc    <= '0;
        gp    <= 1'b0;
        led_r <= 1'b0;
      end else if (wr) begin
        st    <= cfg.cfg_mode[1] ? (cfg.cfg_mode[0] ? U_HI : B_HI) : IDLE;
        half  <= cfg.cfg_half == '0 ? HALF_W'(1) : cfg.cfg_half;
        burst <= cfg.cfg_burst == '0 ? 4'd1 : cfg.cfg_burst;
        timer <= '0;
        pc    <= '0;
        gp    <= 1'b0;
        led_r <= |cfg.cfg_mode;
      end else if (tick_c && st != IDLE) begin
        if (timer == half - 1'b1) begin
          timer <= '0;
          case (st)
            B_HI: begin st <= B_LO; led_r <= 1'b0; end
            B_LO: begin st <= B_HI; led_r <= 1'b1; end
            U_HI: begin st <= U_LO; led_r <= 1'b0; end
            U_LO:
              if (pc == burst - 1'b1) begin
                st <= GAP;
                pc <= '0;
                gp <= 1'b0;
              end else begin
                st    <= U_HI;
                pc    <= pc + 4'd1;
                led_r <= 1'b1;
              end
            GAP:
              if (gp) begin
                st    <= U_HI;
                gp    <= 1'b0;
                led_r <= 1'b1;
              end else gp <= 1'b1;
            default: st <= IDLE;
          endcase
        end else timer <= timer + 1'b1;
      end
  end
endmodule

// File: doc/led_blink_array.md
Name: led_blink_array

Overview:
- Multi-channel, parametrised LED pattern generator for board bring-up and status indication.
- A single free-running prescaler produces a shared tick.
- Each channel holds its own run-time configuration: mode, half-period and burst count.
- Channels run independently and drive registered LED outputs. Replaces fixed-rate single-LED toggling with per-channel OFF/ON/BLINK/BURST modes.

Parameters:
- CHANNELS, 4: number of LED channels (1..16).
- PRESCALE, 50000: clk cycles per tick (>=1).
- HALF_W, 16: width of per-channel half-period, in ticks.
- CH_W (localparam): max(1, clog2(CHANNELS)).

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- cfg_we, input, 1: config write strobe, one-cycle pulse, no backpressure.
- cfg_ch, input, CH_W: target channel index.
- cfg_mode, input, 2: 00 OFF, 01 ON, 10 BLINK, 11 BURST.
- cfg_half, input, HALF_W: ticks per high/low phase; 0 is treated as 1.
- cfg_burst, input, 4: pulses per burst; 0 is treated as 1.
- led, output, CHANNELS: registered LED drive, 1 = lit.
- tick, output, 1: registered copy of the prescaler tick, for debug and sync.

Behaviour:
- Reset (async assert, sync-safe release):
  - prescaler = 0, tick = 0, led = 0.
  - Every channel: mode OFF, half = 1, burst = 1, timer = 0, pulse count = 0, state IDLE.
- Prescaler: counts 0..PRESCALE-1 and wraps.
  - Internal tick_c = (count == PRESCALE-1). PRESCALE = 1 gives tick_c every cycle.
  - tick output = tick_c delayed by 1 cycle.
  - The prescaler is never reset by config writes.
- Config write:
  - On the edge where cfg_we = 1 and cfg_ch < CHANNELS, the channel latches mode/half/burst, clears timer and pulse count, and enters the start state.
  - cfg_ch >= CHANNELS: write ignored.
  - A write outranks a tick on the same edge for that channel; the tick is dropped for that channel only.
  - Start states:
    - OFF: led = 0.
    - ON: led = 1.
    - BLINK: enter B_HI, led = 1.
    - BURST: enter U_HI, led = 1.
  - All take effect on the write edge, so led is visible the next cycle.
- Timer: increments on each tick_c in timed states. A phase ends on the tick where timer == half-1; that tick clears timer to 0 and changes state and led on the same edge.
- BLINK: B_HI (led 1) -> B_LO (led 0) -> B_HI, each phase lasting half ticks. Period = 2·half·PRESCALE cycles, 50% duty.
- BURST:
  - U_HI (led 1, half ticks) -> U_LO (led 0, half ticks).
  - At the end of U_LO:
    - If pulse count == burst-1: -> GAP with count cleared.
    - Otherwise: count += 1, -> U_HI.
  - GAP (led 0) lasts 2·half ticks, then -> U_HI.
  - Pattern period = (2·burst + 2)·half ticks.
- OFF/ON: static; timer frozen at 0; ticks ignored.
- Widths: timer is HALF_W bits, compared against the effective half; half = 2^HALF_W-1 must work without overflow. The GAP count uses an HALF_W+1-bit compare or a two-pass phase bit, never a truncated 2·half.
- Reset mid-pattern: all led go low immediately (async), and the configuration is lost.

Test Plan:
- Reset: assert rst_n = 0 with a pattern running -> led = 0 and tick = 0 in the same cycle. After release with no writes -> led stays 0 for 1000 cycles.
- BLINK, PRESCALE = 4, ch1, half = 3 -> led[1] = 1 the cycle after the write. Steady state: 12 cycles high, 12 cycles low, repeating. Other channels stay 0.
- BURST, PRESCALE = 1, ch0, half = 1, burst = 2 -> led[0] sequence from the cycle after the write: 1,0,1,0,0,0 repeating (period 6).
- half = 0 and burst = 0 on BLINK/BURST -> behaves identically to half = 1 and burst = 1. BURST gives 1,0,0,0 repeating at PRESCALE = 1.
- Write during phase: ch2 BLINK half = 5, then rewrite ch2 to ON on an edge coincident with tick_c -> led[2] = 1 and holds; no toggle on that tick. Rewrite with cfg_ch = CHANNELS -> no change on any channel.
- Independence: ch0 BLINK half = 2 and ch3 BURST half = 1, burst = 3, PRESCALE = 2 -> each matches its standalone reference model cycle-for-cycle over 500 cycles. tick pulses exactly every 2 cycles.
